// File: rtl/snitch_icache_refill_arbiter.sv
// Round-robin arbiter sharing the L0->L1 refill port among the fetch ports.
// It enforces a per-port limit on outstanding refills, routes responses by ID and drains all refills before a flush.
module snitch_icache_refill_arbiter #(
    parameter int unsigned NR_FETCH_PORTS = 2,
    parameter int unsigned FETCH_AW       = 32,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned MAX_PENDING    = 2,
    localparam int unsigned ID_W = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NR_FETCH_PORTS-1:0][FETCH_AW-1:0]  in_addr_i,
    input  logic [NR_FETCH_PORTS-1:0]                in_valid_i,
    output logic [NR_FETCH_PORTS-1:0]                in_ready_o,
    output logic [LINE_WIDTH-1:0]                    in_rsp_data_o,
    output logic                                     in_rsp_error_o,
    output logic [NR_FETCH_PORTS-1:0]                in_rsp_valid_o,
    input  logic [NR_FETCH_PORTS-1:0]                in_rsp_ready_i,
    output logic [FETCH_AW-1:0]                      out_addr_o,
    output logic [ID_W-1:0]                          out_id_o,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    input  logic [LINE_WIDTH-1:0]                    out_rsp_data_i,
    input  logic                                     out_rsp_error_i,
    input  logic [ID_W-1:0]                          out_rsp_id_i,
    input  logic                                     out_rsp_valid_i,
    output logic                                     out_rsp_ready_o,
    input  logic                                     flush_valid_i,
    output logic                                     flush_ready_o,
    output logic                                     busy_o
);
    localparam int unsigned CW = $clog2(MAX_PENDING + 1);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e                    state_q, state_d;
    logic                      lock_q, lock_d;
    logic [ID_W-1:0]           lock_id_q, lock_id_d;
    logic [ID_W-1:0]           rr_q, rr_d;
    logic [CW-1:0]             pend_q [NR_FETCH_PORTS];
    logic [CW-1:0]             pend_d [NR_FETCH_PORTS];

    logic [NR_FETCH_PORTS-1:0] eligible, nonzero, rsp_sel, inc, dec;
    logic                      gnt_valid, req_hs, rsp_legal, rsp_port_ready, rsp_hs, all_idle;
    logic [ID_W-1:0]           gnt;

    always_comb begin
        eligible = '0;
        nonzero  = '0;
        rsp_sel  = '0;
        for (int unsigned i = 0; i < NR_FETCH_PORTS; i++) begin
            eligible[i] = in_valid_i[i] && (pend_q[i] < CW'(MAX_PENDING)) && (state_q == RUN);
            nonzero[i]  = (pend_q[i] != '0);
            rsp_sel[i]  = (out_rsp_id_i == ID_W'(i));
        end
    end

    // A locked grant wins unconditionally so an offered request is never withdrawn.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        if (lock_q) begin
            gnt_valid = 1'b1;
            gnt       = lock_id_q;
        end else begin
            for (int unsigned k = 0; k < NR_FETCH_PORTS; k++) begin
                if (!gnt_valid && eligible[(32'(rr_q) + k) % NR_FETCH_PORTS]) begin
                    gnt_valid = 1'b1;
                    gnt       = ID_W'((32'(rr_q) + k) % NR_FETCH_PORTS);
                end
            end
        end
    end

    assign out_valid_o = rst_ni && gnt_valid;
    assign out_addr_o  = out_valid_o ? in_addr_i[gnt] : '0;
    assign out_id_o    = out_valid_o ? gnt : '0;
    assign req_hs      = out_valid_o && out_ready_i;

    always_comb begin
        in_ready_o = '0;
        for (int unsigned i = 0; i < NR_FETCH_PORTS; i++) begin
            in_ready_o[i] = out_valid_o && (gnt == ID_W'(i)) && out_ready_i;
        end
    end

    // Responses to unknown or idle ports are acknowledged and discarded.
    assign rsp_legal       = |(rsp_sel & nonzero);
    assign rsp_port_ready  = |(rsp_sel & in_rsp_ready_i);
    assign rsp_hs          = out_rsp_valid_i && rsp_legal && rsp_port_ready;
    assign in_rsp_valid_o  = (rst_ni && out_rsp_valid_i && rsp_legal) ? rsp_sel : '0;
    assign out_rsp_ready_o = rst_ni && (rsp_legal ? rsp_port_ready : 1'b1);
    assign in_rsp_data_o   = rst_ni ? out_rsp_data_i : '0;
    assign in_rsp_error_o  = rst_ni && out_rsp_error_i;

    assign all_idle      = ~|nonzero;
    assign flush_ready_o = rst_ni && (state_q == DRAIN) && all_idle && !lock_q && !out_valid_o;
    assign busy_o        = rst_ni && (!all_idle || out_valid_o);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned i = 0; i < NR_FETCH_PORTS; i++) begin
            inc[i]    = req_hs && (gnt == ID_W'(i));
            dec[i]    = rsp_hs && rsp_sel[i];
            pend_d[i] = pend_q[i] + CW'(inc[i]) - CW'(dec[i]);
        end
    end

    always_comb begin
        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        state_d   = state_q;
        if (req_hs) begin
            rr_d   = (gnt == ID_W'(NR_FETCH_PORTS - 1)) ? '0 : gnt + ID_W'(1);
            lock_d = 1'b0;
        end else if (out_valid_o) begin
            lock_d    = 1'b1;
            lock_id_d = gnt;
        end
        case (state_q)
            RUN:     if (flush_valid_i) state_d = DRAIN;
            DRAIN:   if (flush_valid_i && flush_ready_o) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_q      <= '0;
            for (int unsigned i = 0; i < NR_FETCH_PORTS; i++) pend_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_q      <= rr_d;
            for (int unsigned i = 0; i < NR_FETCH_PORTS; i++) pend_q[i] <= pend_d[i];
        end
    end

    rsp_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_rsp_valid_i |-> rsp_legal);

    for (genvar g = 0; g < NR_FETCH_PORTS; g++) begin : gen_pend_chk
        pend_ovf_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(inc[g] && !dec[g] && pend_q[g] == CW'(MAX_PENDING)));
    end
endmodule
